umi_mem_arbiter: RTL and testbench
==================================

# umi_mem_arbiter

Arbitrates N host-side UMI request streams onto the single device-side request port of one umi_mem_agent, and routes the agent's in-order responses back to the requester that issued each request. It sits between several umi_rx_sim/host agents (or RTL masters) and the memory agent, replacing the direct point-to-point connection. Arbitration is round-robin with packet locking, and an ID FIFO tracks outstanding non-posted requests.

## Interface
- N, 2: number of requesters (2..8)
- CW, 32: UMI command width
- AW, 64: UMI address width
- DW, 128: UMI data width
- DEPTH, 4: outstanding non-posted request capacity (power of 2)
- clk  in  1  clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- host_req_valid  in  N  per-requester request valid
- host_req_cmd  in  N*CW  requester i at [i*CW +: CW]
- host_req_dstaddr  in  N*AW  packed per requester
- host_req_srcaddr  in  N*AW  packed per requester
- host_req_data  in  N*DW  packed per requester
- host_req_ready  out  N  per-requester request ready
- udev_req_valid/cmd/dstaddr/srcaddr/data  out  1/CW/AW/AW/DW  to memory agent
- udev_req_ready  in  1  from memory agent
- udev_resp_valid/cmd/dstaddr/srcaddr/data  in  1/CW/AW/AW/DW  from memory agent
- udev_resp_ready  out  1  to memory agent
- host_resp_valid  out  N  per-requester response valid
- host_resp_cmd/dstaddr/srcaddr/data  out  CW/AW/AW/DW  shared response payload, broadcast to all requesters
- host_resp_ready  in  N  per-requester response ready

## Operation
- Opcode = cmd[4:0]; EOM = cmd[22]. Posted opcode REQ_POSTED (5'h05) expects no response; all other request opcodes expect exactly one response packet.
- Request FSM, states IDLE and LOCKED, plus rr_ptr (log2 N bits) and sel.
- IDLE: candidates = requesters with valid high, excluding non-posted requests when ID FIFO is full. sel = first candidate at or after rr_ptr, wrapping from N-1 to 0. Forward the sel payload to udev_req_*, with udev_req_valid = 1 and host_req_ready[sel] = udev_req_ready. All other readies are 0.
- Beat accepted (valid & ready) with EOM=0: go to LOCKED and hold sel.
- LOCKED: forward only sel. Candidacy is not re-evaluated. Leave on the accepted EOM beat.
- On an accepted EOM beat (either state): rr_ptr <= sel+1 mod N. If the opcode is non-posted, push sel into the ID FIFO.
- Response: head = ID FIFO head. host_resp_valid[head] = udev_resp_valid & !empty, and all other host_resp_valid are 0. udev_resp_ready = host_resp_ready[head] & !empty.
- Pop the ID FIFO on an accepted response beat with EOM=1. Multi-beat responses stay routed to head.
- Push and pop in the same cycle are both allowed, including when the FIFO is full, because pop frees the slot the same cycle.
- A response with an empty FIFO is stalled (ready 0), not dropped.

## Timing
- Request path: zero-latency combinational mux; state updates on the clk rising edge.
- Response path: zero-latency combinational demux.
- Reset values: FSM=IDLE, rr_ptr=0, FIFO empty. All host_req_ready, host_resp_valid, udev_req_valid and udev_resp_ready are 0 while reset is high.
- Reset mid-packet or with outstanding IDs: all state is discarded immediately. After reset, the first grant goes to requester 0 if it is valid.
- Fairness: each of N continuously-valid requesters is granted within N packets.

## Structure
- Package umi_arb_pkg holds:
  - UMI_REQ_POSTED and the other opcode localparams
  - UMI_EOM_BIT=22
  - a function is_posted(cmd)
- Sub-module umi_arb_idfifo holds the DEPTH x log2(N) ID FIFO: synchronous push/pop, full/empty flags, async active-high reset.
- Round-robin select and the request FSM stay in the top level.

## Test plan
- Two requesters, N=2, both issue a single-beat REQ_READ every cycle with agent always ready. Grants must alternate 0,1,0,1, and responses return to 0,1,0,1 in order.
- Requester 0 sends a 3-beat REQ_WRITE while requester 1 is valid from cycle 0. All 3 beats of requester 0 must pass before any beat of requester 1.
- DEPTH=4, response ready held 0, requester 0 issues 5 reads:
  - the 5th read is stalled;
  - a posted write from requester 1 is still granted;
  - after one response is accepted, the 5th read proceeds.
- A posted write followed by a read from the same requester leaves one FIFO entry, and exactly one host_resp_valid pulse goes to that requester.
- Response head = requester 1 with host_resp_ready[1]=0 and host_resp_ready[0]=1: udev_resp_ready must be 0 and host_resp_valid[0] must never assert.
- Assert reset while in LOCKED with 2 outstanding IDs. All outputs must be 0 during reset, the FIFO must be empty afterwards, and the next grant must go to requester 0.

Source files
------------

// File: rtl/umi_arb_pkg.sv
// Shared UMI opcode constants, FSM state type and command decode helpers
// for the memory-agent request arbiter.
package umi_arb_pkg;

    localparam int UMI_CW      = 32;
    localparam int UMI_EOM_BIT = 22;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_REQ_RDMA   = 5'h07;
    localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic is_posted(input logic [UMI_CW-1:0] cmd);
        return cmd[4:0] == UMI_REQ_POSTED;
    endfunction

    function automatic logic is_eom(input logic [UMI_CW-1:0] cmd);
        return cmd[UMI_EOM_BIT];
    endfunction

endpackage

// File: rtl/umi_mem_arbiter_if.sv
// Bundle of the N packed host-side UMI ports and the single device-side port.
// slave = arbiter view, master = the surrounding requesters and memory agent.
interface umi_mem_arbiter_if #(
    parameter int N  = 2,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 128
);
    logic [N-1:0]    host_req_valid;
    logic [N*CW-1:0] host_req_cmd;
    logic [N*AW-1:0] host_req_dstaddr;
    logic [N*AW-1:0] host_req_srcaddr;
    logic [N*DW-1:0] host_req_data;
    logic [N-1:0]    host_req_ready;

    logic            udev_req_valid;
    logic [CW-1:0]   udev_req_cmd;
    logic [AW-1:0]   udev_req_dstaddr;
    logic [AW-1:0]   udev_req_srcaddr;
    logic [DW-1:0]   udev_req_data;
    logic            udev_req_ready;

    logic            udev_resp_valid;
    logic [CW-1:0]   udev_resp_cmd;
    logic [AW-1:0]   udev_resp_dstaddr;
    logic [AW-1:0]   udev_resp_srcaddr;
    logic [DW-1:0]   udev_resp_data;
    logic            udev_resp_ready;

    logic [N-1:0]    host_resp_valid;
    logic [CW-1:0]   host_resp_cmd;
    logic [AW-1:0]   host_resp_dstaddr;
    logic [AW-1:0]   host_resp_srcaddr;
    logic [DW-1:0]   host_resp_data;
    logic [N-1:0]    host_resp_ready;

    modport slave (
        input  host_req_valid, host_req_cmd, host_req_dstaddr, host_req_srcaddr, host_req_data,
        output host_req_ready,
        output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        input  udev_req_ready,
        input  udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        output udev_resp_ready,
        output host_resp_valid, host_resp_cmd, host_resp_dstaddr, host_resp_srcaddr, host_resp_data,
        input  host_resp_ready
    );

    modport master (
        output host_req_valid, host_req_cmd, host_req_dstaddr, host_req_srcaddr, host_req_data,
        input  host_req_ready,
        input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        output udev_req_ready,
        output udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        input  udev_resp_ready,
        input  host_resp_valid, host_resp_cmd, host_resp_dstaddr, host_resp_srcaddr, host_resp_data,
        output host_resp_ready
    );

endinterface

// File: rtl/umi_arb_idfifo.sv
// Requester-ID FIFO for outstanding non-posted requests. A pop frees its slot
// in the same cycle, so push is accepted while full if a pop happens too.
module umi_arb_idfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
        end
    end

    // Storage is pure data; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/umi_mem_arbiter.sv
// Round-robin, packet-locked arbiter of N UMI requesters onto one memory agent,
// with in-order response routing driven by a FIFO of requester IDs.
module umi_mem_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 128,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    umi_mem_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] grant_rr, grant, head;
    logic [N-1:0]  cand;
    logic          any_cand, req_vld, req_acc;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        return (int'(p) == N - 1) ? '0 : p + IW'(1);
    endfunction

    // A non-posted request is not a candidate when its ID would have nowhere to go.
    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++)
            cand[i] = bus.host_req_valid[i] &
                      (is_posted(bus.host_req_cmd[i*CW +: CW]) | ~fifo_full);
    end

    // Scan from the farthest position back so the nearest candidate at/after rr_ptr wins.
    always_comb begin
        int idx;
        idx      = 0;
        grant_rr = rr_ptr_q;
        any_cand = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (cand[IW'(idx)]) begin
                grant_rr = IW'(idx);
                any_cand = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        grant     = (state_q == ARB_LOCKED) ? sel_q : grant_rr;
        req_vld   = ((state_q == ARB_LOCKED) ? bus.host_req_valid[sel_q] : any_cand) & ~reset;
        req_acc   = req_vld & bus.udev_req_ready;
        fifo_push = 1'b0;

        bus.udev_req_valid   = req_vld;
        bus.udev_req_cmd     = bus.host_req_cmd[int'(grant)*CW +: CW];
        bus.udev_req_dstaddr = bus.host_req_dstaddr[int'(grant)*AW +: AW];
        bus.udev_req_srcaddr = bus.host_req_srcaddr[int'(grant)*AW +: AW];
        bus.udev_req_data    = bus.host_req_data[int'(grant)*DW +: DW];
        bus.host_req_ready   = '0;
        if (req_vld) bus.host_req_ready[grant] = bus.udev_req_ready;

        if (req_acc) begin
            if (is_eom(bus.udev_req_cmd)) begin
                state_d   = ARB_IDLE;
                rr_ptr_d  = wrap_inc(grant);
                fifo_push = ~is_posted(bus.udev_req_cmd);
            end else begin
                state_d = ARB_LOCKED;
                sel_d   = grant;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
        end
    end

    // Responses arrive in request order, so the FIFO head names their owner.
    always_comb begin
        bus.host_resp_valid = '0;
        bus.udev_resp_ready = 1'b0;
        if (!fifo_empty && !reset) begin
            bus.host_resp_valid[head] = bus.udev_resp_valid;
            bus.udev_resp_ready       = bus.host_resp_ready[head];
        end
    end

    assign fifo_pop = bus.udev_resp_valid & bus.udev_resp_ready & is_eom(bus.udev_resp_cmd);

    assign bus.host_resp_cmd     = bus.udev_resp_cmd;
    assign bus.host_resp_dstaddr = bus.udev_resp_dstaddr;
    assign bus.host_resp_srcaddr = bus.udev_resp_srcaddr;
    assign bus.host_resp_data    = bus.udev_resp_data;

    umi_arb_idfifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_idfifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (grant),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_umi_mem_arbiter.sv
// Scenario bench for umi_mem_arbiter: expected grant order and response owners
// are queued as stimulus is driven and compared as the DUT handshakes.
module tb_umi_mem_arbiter;
    import umi_arb_pkg::*;

    localparam int N     = 2;
    localparam int CW    = 32;
    localparam int AW    = 64;
    localparam int DW    = 128;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_grant_q[$];
    int   exp_resp_q[$];

    umi_mem_arbiter_if #(.N(N), .CW(CW), .AW(AW), .DW(DW)) bus();

    umi_mem_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic eom);
        logic [CW-1:0] c;
        c = '0;
        c[4:0] = op;
        c[UMI_EOM_BIT] = eom;
        return c;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] op, input logic eom, input int seq);
        logic [DW-1:0] d;
        d = '0;
        d[7:0]  = i[7:0];
        d[23:8] = seq[15:0];
        bus.host_req_valid[i]              = v;
        bus.host_req_cmd[i*CW +: CW]       = mk_cmd(op, eom);
        bus.host_req_dstaddr[i*AW +: AW]   = 64'h1000 + 64'(seq);
        bus.host_req_srcaddr[i*AW +: AW]   = 64'(i);
        bus.host_req_data[i*DW +: DW]      = d;
    endtask

    task automatic set_resp(input logic v, input logic [4:0] op, input int seq);
        bus.udev_resp_valid   = v;
        bus.udev_resp_cmd     = mk_cmd(op, 1'b1);
        bus.udev_resp_dstaddr = 64'(seq);
        bus.udev_resp_srcaddr = 64'h0;
        bus.udev_resp_data    = 128'(seq) + 128'h00ab_0000;
    endtask

    task automatic idle_reqs();
        bus.host_req_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.host_req_valid  = '1;
        bus.host_req_cmd    = '0;
        bus.host_req_dstaddr = '0;
        bus.host_req_srcaddr = '0;
        bus.host_req_data   = '0;
        bus.udev_req_ready  = 1'b1;
        bus.host_resp_ready = '1;
        set_req(0, 1'b1, UMI_REQ_READ, 1'b1, 0);
        set_req(1, 1'b1, UMI_REQ_READ, 1'b1, 0);
        set_resp(1'b1, UMI_RESP_READ, 0);
        @(negedge clk);
        #1;
        vectors++;
        if (bus.udev_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_udev_req_valid: got %b want 0", bus.udev_req_valid); end
        vectors++;
        if (bus.host_req_ready !== '0) begin miscompares++; $display("FAIL reset_host_req_ready: got %b want 00", bus.host_req_ready); end
        vectors++;
        if (bus.host_resp_valid !== '0) begin miscompares++; $display("FAIL reset_host_resp_valid: got %b want 00", bus.host_resp_valid); end
        vectors++;
        if (bus.udev_resp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_udev_resp_ready: got %b want 0", bus.udev_resp_ready); end
        @(negedge clk);
        idle_reqs();
        set_resp(1'b0, UMI_RESP_READ, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int got, exp;
        bus.udev_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, UMI_REQ_READ, 1'b1, c);
            set_req(1, 1'b1, UMI_REQ_READ, 1'b1, c);
            exp_grant_q.push_back(c % 2);
            #1;
            got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
            exp = exp_grant_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL alt_grant[%0d]: got %0d want %0d", c, got, exp); end
            vectors++;
            if (bus.host_req_ready !== onehot(exp)) begin miscompares++; $display("FAIL alt_ready[%0d]: got %b want %b", c, bus.host_req_ready, onehot(exp)); end
            if (exp >= 0) exp_resp_q.push_back(exp);
            @(negedge clk);
        end
        idle_reqs();
        bus.host_resp_ready = '1;
        for (int c = 0; c < 4; c++) begin
            set_resp(1'b1, UMI_RESP_READ, c);
            #1;
            exp = exp_resp_q.pop_front();
            vectors++;
            if (bus.host_resp_valid !== onehot(exp)) begin miscompares++; $display("FAIL alt_resp[%0d]: got %b want %b", c, bus.host_resp_valid, onehot(exp)); end
            vectors++;
            if (bus.udev_resp_ready !== 1'b1) begin miscompares++; $display("FAIL alt_resp_ready[%0d]: got %b want 1", c, bus.udev_resp_ready); end
            if (c == 0) begin
                vectors++;
                if (bus.host_resp_data !== 128'h00ab_0000) begin miscompares++; $display("FAIL alt_resp_data: got %h want %h", bus.host_resp_data, 128'h00ab_0000); end
            end
            @(negedge clk);
        end
        set_resp(1'b1, UMI_RESP_READ, 9);
        #1;
        vectors++;
        if (bus.udev_resp_ready !== 1'b0) begin miscompares++; $display("FAIL empty_stall_ready: got %b want 0", bus.udev_resp_ready); end
        vectors++;
        if (bus.host_resp_valid !== '0) begin miscompares++; $display("FAIL empty_stall_valid: got %b want 00", bus.host_resp_valid); end
        @(negedge clk);
        set_resp(1'b0, UMI_RESP_READ, 0);
    endtask

    task automatic test_lock();
        int got, exp;
        bus.udev_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_req(0, c < 3, UMI_REQ_WRITE, c == 2, c);
            set_req(1, 1'b1, UMI_REQ_POSTED, 1'b1, c);
            if (c == 1) begin
                bus.udev_req_ready = 1'b0;
                #1;
                vectors++;
                if (bus.host_req_ready !== '0 || bus.udev_req_valid !== 1'b1 || bus.udev_req_data[7:0] !== 8'd0) begin
                    miscompares++;
                    $display("FAIL lock_stall: got ready %b valid %b tag %0d want 00 1 0",
                             bus.host_req_ready, bus.udev_req_valid, bus.udev_req_data[7:0]);
                end
                @(negedge clk);
                bus.udev_req_ready = 1'b1;
            end
            exp_grant_q.push_back(c < 3 ? 0 : 1);
            #1;
            got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
            exp = exp_grant_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL lock_grant[%0d]: got %0d want %0d", c, got, exp); end
            if (c == 2) exp_resp_q.push_back(0);
            @(negedge clk);
        end
        idle_reqs();
        set_resp(1'b1, UMI_RESP_WRITE, 1);
        #1;
        exp = exp_resp_q.pop_front();
        vectors++;
        if (bus.host_resp_valid !== onehot(exp)) begin miscompares++; $display("FAIL lock_resp: got %b want %b", bus.host_resp_valid, onehot(exp)); end
        @(negedge clk);
        set_resp(1'b0, UMI_RESP_WRITE, 0);
    endtask

    task automatic test_full_stall();
        int got, exp;
        bus.host_resp_ready = '0;
        bus.udev_req_ready  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, UMI_REQ_READ, 1'b1, c);
            set_req(1, c == 5, UMI_REQ_POSTED, 1'b1, c);
            exp_grant_q.push_back(c < 4 ? 0 : (c == 5 ? 1 : -1));
            #1;
            got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
            exp = exp_grant_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL full_grant[%0d]: got %0d want %0d", c, got, exp); end
            if (c < 4) exp_resp_q.push_back(0);
            @(negedge clk);
        end
        set_req(1, 1'b0, UMI_REQ_POSTED, 1'b1, 0);
        bus.host_resp_ready = 2'b01;
        set_resp(1'b1, UMI_RESP_READ, 0);
        exp_grant_q.push_back(-1);
        #1;
        exp = exp_resp_q.pop_front();
        vectors++;
        if (bus.host_resp_valid !== onehot(exp) || bus.udev_resp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_resp: got valid %b ready %b want %b 1", bus.host_resp_valid, bus.udev_resp_ready, onehot(exp));
        end
        got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
        exp = exp_grant_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL full_still_stalled: got %0d want %0d", got, exp); end
        @(negedge clk);
        set_resp(1'b0, UMI_RESP_READ, 0);
        exp_grant_q.push_back(0);
        #1;
        got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
        exp = exp_grant_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL full_resume: got %0d want %0d", got, exp); end
        exp_resp_q.push_back(0);
        @(negedge clk);
        idle_reqs();
        for (int c = 0; c < 4; c++) begin
            set_resp(1'b1, UMI_RESP_READ, c);
            #1;
            exp = exp_resp_q.pop_front();
            vectors++;
            if (bus.host_resp_valid !== onehot(exp)) begin miscompares++; $display("FAIL full_drain[%0d]: got %b want %b", c, bus.host_resp_valid, onehot(exp)); end
            @(negedge clk);
        end
        set_resp(1'b0, UMI_RESP_READ, 0);
    endtask

    task automatic test_posted_read();
        int got, exp;
        bus.host_resp_ready = '1;
        for (int c = 0; c < 2; c++) begin
            set_req(0, 1'b1, (c == 0) ? UMI_REQ_POSTED : UMI_REQ_READ, 1'b1, c);
            exp_grant_q.push_back(0);
            #1;
            got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
            exp = exp_grant_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL pr_grant[%0d]: got %0d want %0d", c, got, exp); end
            if (c == 1) exp_resp_q.push_back(0);
            @(negedge clk);
        end
        idle_reqs();
        for (int c = 0; c < 2; c++) begin
            set_resp(1'b1, UMI_RESP_READ, c);
            #1;
            exp = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : -1;
            vectors++;
            if (bus.host_resp_valid !== onehot(exp)) begin miscompares++; $display("FAIL pr_resp_pulse[%0d]: got %b want %b", c, bus.host_resp_valid, onehot(exp)); end
            @(negedge clk);
        end
        set_resp(1'b0, UMI_RESP_READ, 0);
    endtask

    task automatic test_head_block();
        int got, exp;
        set_req(1, 1'b1, UMI_REQ_READ, 1'b1, 0);
        exp_grant_q.push_back(1);
        #1;
        got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
        exp = exp_grant_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL hb_grant: got %0d want %0d", got, exp); end
        exp_resp_q.push_back(1);
        @(negedge clk);
        idle_reqs();
        bus.host_resp_ready = 2'b01;
        set_resp(1'b1, UMI_RESP_READ, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.udev_resp_ready !== 1'b0 || bus.host_resp_valid !== 2'b10) begin
                miscompares++;
                $display("FAIL hb_blocked[%0d]: got ready %b valid %b want 0 10", c, bus.udev_resp_ready, bus.host_resp_valid);
            end
            @(negedge clk);
        end
        bus.host_resp_ready = 2'b11;
        #1;
        exp = exp_resp_q.pop_front();
        vectors++;
        if (bus.udev_resp_ready !== 1'b1 || bus.host_resp_valid !== onehot(exp)) begin
            miscompares++;
            $display("FAIL hb_release: got ready %b valid %b want 1 %b", bus.udev_resp_ready, bus.host_resp_valid, onehot(exp));
        end
        @(negedge clk);
        set_resp(1'b0, UMI_RESP_READ, 0);
    endtask

    task automatic test_reset_mid();
        int got, exp;
        for (int c = 0; c < 3; c++) begin
            idle_reqs();
            if (c == 0) set_req(1, 1'b1, UMI_REQ_READ, 1'b1, c);
            else        set_req(0, 1'b1, (c == 1) ? UMI_REQ_READ : UMI_REQ_WRITE, c == 1, c);
            exp_grant_q.push_back(c == 0 ? 1 : 0);
            #1;
            got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
            exp = exp_grant_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL rm_setup[%0d]: got %0d want %0d", c, got, exp); end
            if (c < 2) exp_resp_q.push_back(exp);
            @(negedge clk);
        end
        reset = 1'b1;
        set_req(0, 1'b1, UMI_REQ_WRITE, 1'b0, 3);
        set_req(1, 1'b1, UMI_REQ_READ, 1'b1, 3);
        set_resp(1'b1, UMI_RESP_READ, 0);
        #1;
        vectors++;
        if (bus.udev_req_valid !== 1'b0 || bus.host_req_ready !== '0 ||
            bus.host_resp_valid !== '0 || bus.udev_resp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_outputs_in_reset: got %b %b %b %b want 0 00 00 0",
                     bus.udev_req_valid, bus.host_req_ready, bus.host_resp_valid, bus.udev_resp_ready);
        end
        @(negedge clk);
        exp_resp_q.delete();
        idle_reqs();
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.udev_resp_ready !== 1'b0 || bus.host_resp_valid !== '0) begin
            miscompares++;
            $display("FAIL rm_fifo_empty: got ready %b valid %b want 0 00", bus.udev_resp_ready, bus.host_resp_valid);
        end
        @(negedge clk);
        set_resp(1'b0, UMI_RESP_READ, 0);
        set_req(0, 1'b1, UMI_REQ_READ, 1'b1, 4);
        set_req(1, 1'b1, UMI_REQ_READ, 1'b1, 4);
        exp_grant_q.push_back(0);
        #1;
        got = (bus.udev_req_valid && bus.udev_req_ready) ? int'(bus.udev_req_data[7:0]) : -1;
        exp = exp_grant_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL rm_first_grant: got %0d want %0d", got, exp); end
        exp_resp_q.push_back(exp);
        @(negedge clk);
        idle_reqs();
        set_resp(1'b1, UMI_RESP_READ, 5);
        #1;
        exp = exp_resp_q.pop_front();
        vectors++;
        if (bus.host_resp_valid !== onehot(exp)) begin miscompares++; $display("FAIL rm_resp: got %b want %b", bus.host_resp_valid, onehot(exp)); end
        @(negedge clk);
        set_resp(1'b0, UMI_RESP_READ, 0);
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_full_stall();
        test_posted_read();
        test_head_block();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
